// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C slave receiver.
package i2c_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_WRITE,
    ST_WRITE_ACK,
    ST_READ,
    ST_READ_ACK
  } state_e;

  localparam logic I2C_ACK  = 1'b0;
  localparam logic I2C_NACK = 1'b1;

  localparam logic RW_WRITE = 1'b0;
  localparam logic RW_READ  = 1'b1;

endpackage

// File: rtl/i2c_sync_edge.sv
// Input synchronizer for one bus line with a history flop for edge pulses.
module i2c_sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic [STAGES-1:0] sync_q;
  logic              hist_q;

  // Reset to 1 so an idle bus produces no edges after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '1;
      hist_q <= 1'b1;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
      hist_q <= sync_q[STAGES-1];
    end
  end

  assign level_o = sync_q[STAGES-1];
  assign rise_o  = level_o & ~hist_q;
  assign fall_o  = ~level_o & hist_q;

endmodule

// File: rtl/i2c_slave_rx.sv
// Open-drain I2C slave target: address match, write receive, read serve.
module i2c_slave_rx
  import i2c_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDR  = 7'b1010100,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_oe,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_req,
  output logic       rw_bit,
  output logic       busy
);

  logic scl_lvl, scl_rise, scl_fall;
  logic sda_lvl, sda_rise, sda_fall;
  logic start_det, stop_det;

  i2c_sync_edge #(.STAGES(SYNC_STAGES)) u_scl (
    .clk(clk), .rst_n(reset), .d_i(scl_in),
    .level_o(scl_lvl), .rise_o(scl_rise), .fall_o(scl_fall)
  );

  i2c_sync_edge #(.STAGES(SYNC_STAGES)) u_sda (
    .clk(clk), .rst_n(reset), .d_i(sda_in),
    .level_o(sda_lvl), .rise_o(sda_rise), .fall_o(sda_fall)
  );

  assign start_det = sda_fall & scl_lvl;
  assign stop_det  = sda_rise & scl_lvl;

  state_e     state_q, state_d;
  logic [2:0] bitcnt_q, bitcnt_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       done_q, done_d;
  logic       match_q, match_d;
  logic       ack_q, ack_d;
  logic       oe_q, oe_d;
  logic       rxv_q, rxv_d;
  logic       txr_q, txr_d;
  logic       rw_q, rw_d;
  logic       busy_q, busy_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      bitcnt_q  <= '0;
      shift_q   <= '0;
      rx_data_q <= '0;
      done_q    <= 1'b0;
      match_q   <= 1'b0;
      ack_q     <= 1'b0;
      oe_q      <= 1'b0;
      rxv_q     <= 1'b0;
      txr_q     <= 1'b0;
      rw_q      <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      bitcnt_q  <= bitcnt_d;
      shift_q   <= shift_d;
      rx_data_q <= rx_data_d;
      done_q    <= done_d;
      match_q   <= match_d;
      ack_q     <= ack_d;
      oe_q      <= oe_d;
      rxv_q     <= rxv_d;
      txr_q     <= txr_d;
      rw_q      <= rw_d;
      busy_q    <= busy_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    bitcnt_d  = bitcnt_q;
    shift_d   = shift_q;
    rx_data_d = rx_data_q;
    done_d    = done_q;
    match_d   = match_q;
    ack_d     = ack_q;
    oe_d      = oe_q;
    rxv_d     = 1'b0;
    txr_d     = 1'b0;
    rw_d      = rw_q;
    busy_d    = busy_q;
    // Bus conditions win over any clock edge seen on the same cycle.
    if (start_det || stop_det) begin
      state_d  = start_det ? ST_ADDR : ST_IDLE;
      bitcnt_d = '0;
      done_d   = 1'b0;
      oe_d     = 1'b0;
      busy_d   = 1'b0;
    end else begin
      unique case (state_q)
        ST_ADDR: begin
          if (scl_rise) begin
            shift_d  = {shift_q[6:0], sda_lvl};
            bitcnt_d = bitcnt_q + 3'd1;
            if (bitcnt_q == 3'd7) begin
              done_d  = 1'b1;
              match_d = (shift_q[6:0] == SLAVE_ADDR);
              rw_d    = sda_lvl;
            end
          end else if (scl_fall && done_q) begin
            done_d = 1'b0;
            if (match_q) begin
              oe_d    = 1'b1;
              busy_d  = 1'b1;
              state_d = ST_ADDR_ACK;
            end else begin
              state_d = ST_IDLE;
            end
          end
        end
        ST_ADDR_ACK: begin
          if (scl_fall) begin
            bitcnt_d = '0;
            if (rw_q == RW_READ) begin
              txr_d   = 1'b1;
              shift_d = tx_data;
              oe_d    = ~tx_data[7];
              state_d = ST_READ;
            end else begin
              oe_d    = 1'b0;
              state_d = ST_WRITE;
            end
          end
        end
        ST_WRITE: begin
          if (scl_rise) begin
            shift_d  = {shift_q[6:0], sda_lvl};
            bitcnt_d = bitcnt_q + 3'd1;
            if (bitcnt_q == 3'd7) begin
              rx_data_d = {shift_q[6:0], sda_lvl};
              rxv_d     = 1'b1;
              done_d    = 1'b1;
            end
          end else if (scl_fall && done_q) begin
            done_d  = 1'b0;
            oe_d    = 1'b1;
            state_d = ST_WRITE_ACK;
          end
        end
        ST_WRITE_ACK: begin
          if (scl_fall) begin
            oe_d    = 1'b0;
            state_d = ST_WRITE;
          end
        end
        ST_READ: begin
          // Each fall ends the high phase of the bit currently on the bus.
          if (scl_fall) begin
            if (bitcnt_q == 3'd7) begin
              bitcnt_d = '0;
              oe_d     = 1'b0;
              state_d  = ST_READ_ACK;
            end else begin
              bitcnt_d = bitcnt_q + 3'd1;
              shift_d  = {shift_q[6:0], 1'b0};
              oe_d     = ~shift_q[6];
            end
          end
        end
        ST_READ_ACK: begin
          if (scl_rise) begin
            ack_d = sda_lvl;
          end else if (scl_fall) begin
            if (ack_q == I2C_ACK) begin
              txr_d   = 1'b1;
              shift_d = tx_data;
              oe_d    = ~tx_data[7];
              state_d = ST_READ;
            end else begin
              oe_d    = 1'b0;
              busy_d  = 1'b0;
              state_d = ST_IDLE;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign sda_oe   = oe_q;
  assign rx_data  = rx_data_q;
  assign rx_valid = rxv_q;
  assign tx_req   = txr_q;
  assign rw_bit   = rw_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_i2c_slave_rx.sv
// Bench for i2c_slave_rx: bit-banged master, vector table, random transactions.
module tb_i2c_slave_rx;

  localparam int Q = 4;

  logic       clk;
  logic       reset;
  logic       scl_m;
  logic       sda_m;
  logic       ovr;
  logic       sda_in;
  logic       sda_oe;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_req;
  logic       rw_bit;
  logic       busy;

  int nerr = 0;
  int nchk = 0;
  logic [7:0] rxq[$];
  int txc = 0;

  // Open-drain wired-AND; ovr lets the master force a STOP past the slave.
  assign sda_in = ovr ? sda_m : (sda_m & ~sda_oe);

  i2c_slave_rx dut (
    .clk(clk), .reset(reset),
    .scl_in(scl_m), .sda_in(sda_in), .sda_oe(sda_oe),
    .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_req(tx_req),
    .rw_bit(rw_bit), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rx_valid) rxq.push_back(rx_data);
    if (tx_req) txc++;
  end

  typedef struct {
    logic [7:0] addr;
    int         nb;
    logic [7:0] d0, d1, d2;
    bit         exp_ack;
    bit         lat;
  } vec_t;

  task automatic wq(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic bit ref_ack(input logic [7:0] a);
    return (int'(a) / 2) == 84;
  endfunction

  // mode 1: rx_valid latency on rise; mode 2: sda_oe latency on fall
  task automatic clk_bit(input logic b, input int mode, output logic s,
                         output logic oe_and, output logic oe_or);
    sda_m = b;
    wq(Q);
    scl_m  = 1'b1;
    oe_and = 1'b1;
    oe_or  = 1'b0;
    s      = 1'b1;
    for (int i = 0; i < 2*Q; i++) begin
      wq(1);
      oe_and &= sda_oe;
      oe_or  |= sda_oe;
      if (mode == 1 && i == 1) chk("rxv_lat_early", rx_valid, 0);
      if (mode == 1 && i == 2) chk("rxv_lat", rx_valid, 1);
      if (i == Q-1) s = sda_in;
    end
    scl_m = 1'b0;
    for (int i = 0; i < Q; i++) begin
      wq(1);
      if (mode == 2 && i == 1) chk("oe_lat_early", sda_oe, 0);
      if (mode == 2 && i == 2) chk("oe_lat", sda_oe, 1);
    end
  endtask

  task automatic start_c();
    sda_m = 1'b1; wq(Q);
    scl_m = 1'b1; wq(Q);
    sda_m = 1'b0; wq(Q);
    scl_m = 1'b0; wq(Q);
  endtask

  task automatic stop_c();
    sda_m = 1'b0; wq(Q);
    scl_m = 1'b1; wq(Q);
    sda_m = 1'b1; wq(Q);
  endtask

  task automatic send_byte(input logic [7:0] b, input int mode,
                           output logic ack, output logic a9,
                           output logic o9);
    logic s, a, o;
    for (int i = 7; i >= 0; i--)
      clk_bit(b[i], (i == 0) ? mode : 0, s, a, o);
    clk_bit(1'b1, 0, ack, a9, o9);
  endtask

  task automatic read_byte(input logic mack, input logic [7:0] nxt,
                           output logic [7:0] b);
    logic s, a, o;
    for (int i = 7; i >= 0; i--) begin
      clk_bit(1'b1, 0, s, a, o);
      b[i] = s;
    end
    tx_data = nxt;
    clk_bit(mack, 0, s, a, o);
  endtask

  task automatic clr();
    rxq.delete();
    txc = 0;
  endtask

  task automatic run_txn(input vec_t v);
    logic [7:0] d[3];
    logic [7:0] rb;
    logic ack, a9, o9;
    bit rd;
    d[0] = v.d0; d[1] = v.d1; d[2] = v.d2;
    rd = v.addr[0];
    clr();
    if (rd) tx_data = d[0];
    start_c();
    send_byte(v.addr, v.lat ? 2 : 0, ack, a9, o9);
    chk("addr_ack", ack, v.exp_ack ? 0 : 1);
    if (v.exp_ack) begin
      chk("addr_oe9", a9, 1);
      chk("busy_on", busy, 1);
      chk("rw_bit", rw_bit, rd);
      if (!rd) begin
        for (int k = 0; k < v.nb; k++) begin
          send_byte(d[k], (v.lat && k == 0) ? 1 : 0, ack, a9, o9);
          chk("data_ack", ack, 0);
          chk("data_oe9", a9, 1);
        end
      end else begin
        for (int k = 0; k < v.nb; k++) begin
          read_byte((k == v.nb-1) ? 1'b1 : 1'b0,
                    (k < 2) ? d[k+1] : 8'h00, rb);
          chk("read_bits", rb, d[k]);
        end
        chk("nack_idle", busy, 0);
      end
    end else begin
      chk("nack_oe", o9, 0);
      chk("busy_off", busy, 0);
    end
    stop_c();
    chk("stop_busy", busy, 0);
    chk("stop_oe", sda_oe, 0);
    chk("rx_cnt", rxq.size(), (v.exp_ack && !rd) ? v.nb : 0);
    if (v.exp_ack && !rd)
      for (int k = 0; k < v.nb && k < rxq.size(); k++)
        chk("rx_byte", rxq[k], d[k]);
    chk("txreq_cnt", txc, (v.exp_ack && rd) ? v.nb : 0);
  endtask

  vec_t tbl[5];

  initial begin
    logic ack, a9, o9, s, a, o;
    vec_t v;
    tbl[0] = '{8'hA8, 1, 8'hAA, 8'h00, 8'h00, 1'b1, 1'b1};
    tbl[1] = '{8'hAA, 1, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0};
    tbl[2] = '{8'hA9, 2, 8'h3C, 8'hC3, 8'h00, 1'b1, 1'b0};
    tbl[3] = '{8'hA8, 2, 8'h12, 8'h34, 8'h00, 1'b1, 1'b0};
    tbl[4] = '{8'hA9, 3, 8'h00, 8'hFF, 8'h81, 1'b1, 1'b0};

    scl_m = 1'b1; sda_m = 1'b1; ovr = 1'b0; tx_data = 8'h00;
    reset = 1'b1;
    #1 reset = 1'b0;
    wq(3);
    chk("rst_oe", sda_oe, 0);
    chk("rst_rxd", rx_data, 0);
    chk("rst_rxv", rx_valid, 0);
    chk("rst_txr", tx_req, 0);
    chk("rst_rw", rw_bit, 0);
    chk("rst_busy", busy, 0);
    reset = 1'b1;
    wq(4);

    for (int i = 0; i < 5; i++) run_txn(tbl[i]);

    // Repeated START after four data bits of a write
    clr();
    start_c();
    send_byte(8'hA8, 0, ack, a9, o9);
    chk("rs_ack1", ack, 0);
    clk_bit(1'b1, 0, s, a, o);
    clk_bit(1'b0, 0, s, a, o);
    clk_bit(1'b1, 0, s, a, o);
    clk_bit(1'b1, 0, s, a, o);
    start_c();
    send_byte(8'hA8, 0, ack, a9, o9);
    chk("rs_ack2", ack, 0);
    chk("rs_oe9", a9, 1);
    send_byte(8'h5A, 0, ack, a9, o9);
    stop_c();
    chk("rs_rx_cnt", rxq.size(), 1);
    chk("rs_rx_data", rx_data, 8'h5A);

    // STOP mid-byte of a read while the slave drives 0
    clr();
    tx_data = 8'h00;
    start_c();
    send_byte(8'hA9, 0, ack, a9, o9);
    chk("sp_ack", ack, 0);
    for (int i = 0; i < 3; i++) clk_bit(1'b1, 0, s, a, o);
    chk("sp_drv0", sda_oe, 1);
    ovr = 1'b1;
    sda_m = 1'b0; wq(Q);
    scl_m = 1'b1; wq(Q);
    sda_m = 1'b1; wq(2);
    chk("sp_pre", sda_oe, 1);
    wq(1);
    chk("sp_rel", sda_oe, 0);
    chk("sp_busy", busy, 0);
    ovr = 1'b0;
    wq(Q);
    clk_bit(1'b1, 0, s, a, o);
    chk("sp_idle", o, 0);

    // Reset during WRITE_ACK
    start_c();
    send_byte(8'hA8, 0, ack, a9, o9);
    chk("ra_ack", ack, 0);
    for (int i = 7; i >= 0; i--) clk_bit(i[0], 0, s, a, o);
    sda_m = 1'b1; wq(Q);
    scl_m = 1'b1; wq(2);
    chk("ra_oe_on", sda_oe, 1);
    #1 reset = 1'b0;
    #1;
    chk("ra_oe_async", sda_oe, 0);
    chk("ra_rxd", rx_data, 0);
    chk("ra_rxv", rx_valid, 0);
    chk("ra_txr", tx_req, 0);
    chk("ra_rw", rw_bit, 0);
    chk("ra_busy", busy, 0);
    wq(4);
    reset = 1'b1;
    wq(4);
    v = '{8'hA8, 1, 8'h11, 8'h00, 8'h00, 1'b1, 1'b0};
    run_txn(v);

    // Randomized transactions against the address/byte model
    for (int n = 0; n < 12; n++) begin
      v.addr = ($urandom_range(0, 1) == 1)
               ? {7'h54, 1'($urandom_range(0, 1))}
               : 8'($urandom);
      v.nb  = $urandom_range(1, 3);
      v.d0  = 8'($urandom);
      v.d1  = 8'($urandom);
      v.d2  = 8'($urandom);
      v.exp_ack = ref_ack(v.addr);
      v.lat = 1'b0;
      run_txn(v);
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/i2c_slave_rx.md
Name: i2c_slave_rx

Overview:
- Synthesizable I2C slave target; sits directly downstream of the I2C master on the shared SDL/SCL bus.
- Oversamples SCL/SDA on the system clock and detects START/STOP.
- Matches a 7-bit address and ACKs it, delivers written bytes to local logic, and serves read bytes from local logic.
- Open-drain only: drives the bus low via an output enable and never drives it high.

Parameters:
- SLAVE_ADDR, 7'b1010100, 7-bit address this target answers to. The master's first byte is 8'b10101000 (address + W).
- SYNC_STAGES, 2, number of flops in the SCL/SDA input synchronizers (>=2).

Ports:
- clk  input  1  system clock; must be >= 8x SCL frequency.
- reset  input  1  asynchronous, active-low reset.
- scl_in  input  1  raw SCL from the bus.
- sda_in  input  1  raw SDA from the bus (the SDL net).
- sda_oe  output  1  1 = pull SDA low; 0 = release (high-Z). The top level ties the pad as SDL = sda_oe ? 0 : z.
- rx_data  output  8  last byte written by the master.
- rx_valid  output  1  one-clk pulse when rx_data is updated.
- tx_data  input  8  byte to return on a read; sampled when tx_req pulses.
- tx_req  output  1  one-clk pulse; local logic must have tx_data stable on that same clk.
- rw_bit  output  1  R/W bit of the current matched transaction (1 = read).
- busy  output  1  high from address match until STOP or a non-matching/NACK exit.

Behaviour:
- Reset (asynchronous, active-low): the following outputs go to 0: sda_oe, rx_data, rx_valid, tx_req, rw_bit, busy. State goes to IDLE, the bit counter to 0, and synchronizer flops to 1 (bus idle). Reset mid-transfer releases SDA immediately, with no glitch low.
- Synchronizers: SYNC_STAGES flops per line, plus one history flop for edge detection.
  - scl_rise / scl_fall: single-clk pulses.
  - START: SDA falls while SCL = 1.
  - STOP: SDA rises while SCL = 1.
- Sampling and driving:
  - Received SDA is sampled on scl_rise.
  - sda_oe changes only on scl_fall, except at START/STOP/reset, where it is released at once.
- State machine states: IDLE, ADDR, ADDR_ACK, WRITE, WRITE_ACK, READ, READ_ACK.
- Global transitions:
  - START from any state → ADDR, with bitcnt = 0, sda_oe = 0, busy = 0. This covers repeated START.
  - STOP from any state → IDLE, with sda_oe = 0, busy = 0.
- IDLE: waits for START.
- ADDR:
  - Shifts in 8 bits MSB-first on scl_rise.
  - On the 8th rise, compares shift[7:1] to SLAVE_ADDR and latches rw_bit = shift[0].
  - On the following scl_fall:
    - Match → sda_oe = 1, busy = 1, ADDR_ACK.
    - Mismatch → IDLE, bus untouched.
- ADDR_ACK: on the scl_fall that ends the ACK clock:
  - rw_bit = 0 → release SDA, go to WRITE.
  - rw_bit = 1 → pulse tx_req, load tx_data into the shift register, drive sda_oe = ~tx_data[7], go to READ.
- WRITE:
  - Shifts 8 bits on scl_rise.
  - On the 8th rise: rx_data <= byte, rx_valid pulses one clk.
  - Next scl_fall: sda_oe = 1, go to WRITE_ACK.
  - Every byte is ACKed; there is no back-pressure.
- WRITE_ACK: on scl_fall, release SDA, go to WRITE (next byte).
- READ:
  - Each scl_fall advances to the next bit: sda_oe = ~bit.
  - After bit 0 has been on the bus through its high phase, the next scl_fall releases SDA and goes to READ_ACK.
- READ_ACK: sample the master's ACK on scl_rise.
  - SDA = 0 (ACK): on scl_fall, pulse tx_req, load a new byte, drive its MSB, go to READ.
  - SDA = 1 (NACK): on scl_fall, release SDA, busy = 0, go to IDLE; then await STOP/START.
- Bit counter: 3 bits, wraps 7→0 at each byte boundary. No 9th-bit counting outside the *_ACK states.
- Simultaneous events: START/STOP take priority over scl edges on the same clk. An scl_rise and scl_fall cannot coincide after synchronization.
- Latency:
  - sda_oe follows the synchronized scl_fall by exactly 1 clk, i.e. SYNC_STAGES+1 clks after the raw edge.
  - rx_valid follows the 8th raw scl rise by SYNC_STAGES+1 clks.

Decomposition:
- Shared package i2c_pkg:
  - State enum for the slave FSM.
  - Constant I2C_ACK = 1'b0, I2C_NACK = 1'b1.
  - Constant RW_WRITE = 0, RW_READ = 1.
- One sub-module: i2c_sync_edge.
  - Parameterised synchronizer plus history flop for one line.
  - Outputs the filtered level, rise and fall.
  - Instantiated twice, once for SCL and once for SDA.
  - START/STOP decode stays in i2c_slave_rx.

Test Plan:
- Write 0xAA to address 0x54:
  - Master sends START, byte 0xA8, byte 0xAA, STOP.
  - Required: sda_oe = 1 for the full 9th clock of both bytes.
  - rx_valid pulses exactly once, with rx_data = 0xAA.
  - busy = 1 from first ACK until STOP.
- Address mismatch: master sends 0xAA (address 0x55, W).
  - Required: sda_oe stays 0 throughout; no rx_valid; busy = 0; the master sees NACK (SDA = 1) on the 9th clock.
- Two-byte read:
  - Master sends 0xA9; tx_data = 0x3C, then 0xC3; master ACKs byte 1 and NACKs byte 2.
  - Required: bus bits are 00111100, then 11000011.
  - tx_req pulses exactly twice; FSM returns to IDLE after the NACK.
- Repeated START after 4 data bits of a write:
  - Then address 0xA8 and data 0x5A.
  - Required: the partial byte is discarded (no rx_valid for it).
  - Address is re-ACKed; rx_data = 0x5A.
- STOP mid-byte during a read while the slave is driving 0:
  - Required: sda_oe = 0 within 1 clk of the synchronized STOP; state IDLE.
- Reset asserted (reset = 0) during a WRITE_ACK:
  - Required: sda_oe drops to 0 asynchronously, all outputs are 0, state IDLE.
  - After release, a fresh write of 0x11 is received correctly.
